ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline. It takes decoded operands from the ID/EX register, computes the ALU result or memory address, and registers the EX/MEM pipeline outputs that the memory stage consumes. It also contains an iterative 32-cycle multiplier with HI/LO registers. While a multiply is in progress, the multiplier stalls the upstream pipeline.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/ex_stage_if.sv | 39 +++
 rtl/mul_iter.sv | 103 ++++++++++
 rtl/ex_stage.sv | 87 ++++++++
 tb/tb_ex_stage.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared ALU opcode encoding and multiplier state type
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOR   = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_SLTU  = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10,
        ALU_LUI   = 4'd11,
        ALU_MULT  = 4'd12,
        ALU_MULTU = 4'd13,
        ALU_MFHI  = 4'd14,
        ALU_MFLO  = 4'd15
    } aluop_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX inputs and EX/MEM outputs of the execute stage
interface ex_stage_if #(
    parameter int MEM_AW = 7
) ();
    logic [3:0]        id_ex_aluop;
    logic [31:0]       id_ex_a;
    logic [31:0]       id_ex_b;
    logic [31:0]       id_ex_imm;
    logic              id_ex_selalub;
    logic [4:0]        id_ex_shamt;
    logic [4:0]        id_ex_regdest;
    logic              id_ex_writereg;
    logic              id_ex_memread;
    logic              id_ex_memwrite;
    logic              ex_stall;
    logic [4:0]        ex_mem_regdest;
    logic              ex_mem_writereg;
    logic              ex_mem_selwsource;
    logic [31:0]       ex_mem_wbvalue;
    logic [MEM_AW-1:0] ex_mem_addr;
    logic [31:0]       ex_mem_data_in;
    logic              ex_mem_wre;

    modport master (
        output id_ex_aluop, id_ex_a, id_ex_b, id_ex_imm, id_ex_selalub,
               id_ex_shamt, id_ex_regdest, id_ex_writereg, id_ex_memread,
               id_ex_memwrite,
        input  ex_stall, ex_mem_regdest, ex_mem_writereg, ex_mem_selwsource,
               ex_mem_wbvalue, ex_mem_addr, ex_mem_data_in, ex_mem_wre
    );

    modport slave (
        input  id_ex_aluop, id_ex_a, id_ex_b, id_ex_imm, id_ex_selalub,
               id_ex_shamt, id_ex_regdest, id_ex_writereg, id_ex_memread,
               id_ex_memwrite,
        output ex_stall, ex_mem_regdest, ex_mem_writereg, ex_mem_selwsource,
               ex_mem_wbvalue, ex_mem_addr, ex_mem_data_in, ex_mem_wre
    );
endinterface

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative shift-add multiplier owning HI/LO
module mul_iter
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    mul_state_e  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [32:0] mplier_q, mplier_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // 33-bit magnitudes so that -2^31 negates without overflow
    logic        a_neg, b_neg;
    logic [32:0] mag_a, mag_b;
    logic [63:0] step_acc, product;

    assign a_neg    = signed_i & a_i[31];
    assign b_neg    = signed_i & b_i[31];
    assign mag_a    = a_neg ? (33'd0 - {a_i[31], a_i}) : {1'b0, a_i};
    assign mag_b    = b_neg ? (33'd0 - {b_i[31], b_i}) : {1'b0, b_i};
    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    assign product  = neg_q ? (64'd0 - step_acc) : step_acc;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

    // next-state, datapath step and stall request
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stall_o  = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    stall_o  = 1'b1;
                    state_d  = MUL_BUSY;
                    count_d  = '0;
                    acc_d    = 64'd0;
                    mcand_d  = {31'd0, mag_a};
                    mplier_d = mag_b;
                    neg_d    = a_neg ^ b_neg;
                end
            end
            MUL_BUSY: begin
                stall_o  = 1'b1;
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == CW'(MUL_CYCLES - 1)) begin
                    {hi_d, lo_d} = product;
                    state_d      = MUL_DONE;
                end
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // multiplier state and HI/LO registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= MUL_IDLE;
            count_q  <= '0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 33'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, EX/MEM register, multiplier hookup
module ex_stage
    import mips_pkg::*;
#(
    parameter int MEM_AW     = 7,
    parameter int MUL_CYCLES = 32
) (
    input  logic       clock,
    input  logic       reset,
    ex_stage_if.slave  bus
);
    logic [31:0] opb;
    logic [31:0] result;
    logic [31:0] hi, lo;
    logic        is_mul, stall, bubble;

    assign opb    = bus.id_ex_selalub ? bus.id_ex_imm : bus.id_ex_b;
    assign is_mul = (bus.id_ex_aluop == ALU_MULT) || (bus.id_ex_aluop == ALU_MULTU);
    // a retiring multiply writes nothing back, same as a stall bubble
    assign bubble = stall | is_mul;
    assign bus.ex_stall = stall;

    mul_iter #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clock    (clock),
        .reset    (reset),
        .start_i  (is_mul),
        .signed_i (bus.id_ex_aluop == ALU_MULT),
        .a_i      (bus.id_ex_a),
        .b_i      (bus.id_ex_b),
        .stall_o  (stall),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    // ALU result selection
    always_comb begin
        result = 32'd0;
        case (bus.id_ex_aluop)
            ALU_ADD:  result = bus.id_ex_a + opb;
            ALU_SUB:  result = bus.id_ex_a - opb;
            ALU_AND:  result = bus.id_ex_a & opb;
            ALU_OR:   result = bus.id_ex_a | opb;
            ALU_XOR:  result = bus.id_ex_a ^ opb;
            ALU_NOR:  result = ~(bus.id_ex_a | opb);
            ALU_SLT:  result = {31'd0, $signed(bus.id_ex_a) < $signed(opb)};
            ALU_SLTU: result = {31'd0, bus.id_ex_a < opb};
            ALU_SLL:  result = bus.id_ex_b << bus.id_ex_shamt;
            ALU_SRL:  result = bus.id_ex_b >> bus.id_ex_shamt;
            ALU_SRA:  result = $unsigned($signed(bus.id_ex_b) >>> bus.id_ex_shamt);
            ALU_LUI:  result = {bus.id_ex_imm[15:0], 16'd0};
            ALU_MFHI: result = hi;
            ALU_MFLO: result = lo;
            default:  result = 32'd0;
        endcase
    end

    // EX/MEM pipeline register, loaded with a bubble while stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.ex_mem_regdest    <= 5'd0;
            bus.ex_mem_writereg   <= 1'b0;
            bus.ex_mem_selwsource <= 1'b0;
            bus.ex_mem_wbvalue    <= 32'd0;
            bus.ex_mem_addr       <= '0;
            bus.ex_mem_data_in    <= 32'd0;
            bus.ex_mem_wre        <= 1'b0;
        end else if (bubble) begin
            bus.ex_mem_regdest    <= bus.id_ex_regdest;
            bus.ex_mem_writereg   <= 1'b0;
            bus.ex_mem_selwsource <= 1'b0;
            bus.ex_mem_wbvalue    <= 32'd0;
            bus.ex_mem_addr       <= '0;
            bus.ex_mem_data_in    <= 32'd0;
            bus.ex_mem_wre        <= 1'b0;
        end else begin
            bus.ex_mem_regdest    <= bus.id_ex_regdest;
            bus.ex_mem_writereg   <= bus.id_ex_writereg;
            bus.ex_mem_selwsource <= bus.id_ex_memread;
            bus.ex_mem_wbvalue    <= result;
            bus.ex_mem_addr       <= result[MEM_AW+1:2];
            bus.ex_mem_data_in    <= bus.id_ex_b;
            bus.ex_mem_wre        <= bus.id_ex_memwrite;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for the execute stage
module tb_ex_stage;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] wb;
        logic [6:0]  addr;
        logic [31:0] data;
        logic        wre;
        logic        sel;
        logic        wr;
        logic [4:0]  rd;
    } exp_t;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    ex_stage_if #(.MEM_AW(7)) bus ();

    ex_stage #(.MEM_AW(7), .MUL_CYCLES(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic sel, input logic [4:0] shamt,
                         input logic [4:0] rd, input logic wr, input logic mr, input logic mw);
        bus.id_ex_aluop    = op;
        bus.id_ex_a        = a;
        bus.id_ex_b        = b;
        bus.id_ex_imm      = imm;
        bus.id_ex_selalub  = sel;
        bus.id_ex_shamt    = shamt;
        bus.id_ex_regdest  = rd;
        bus.id_ex_writereg = wr;
        bus.id_ex_memread  = mr;
        bus.id_ex_memwrite = mw;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_wb"},   bus.ex_mem_wbvalue, e.wb);
            check({tag, "_addr"}, {25'd0, bus.ex_mem_addr}, {25'd0, e.addr});
            check({tag, "_data"}, bus.ex_mem_data_in, e.data);
            check({tag, "_wre"},  {31'd0, bus.ex_mem_wre}, {31'd0, e.wre});
            check({tag, "_sel"},  {31'd0, bus.ex_mem_selwsource}, {31'd0, e.sel});
            check({tag, "_wr"},   {31'd0, bus.ex_mem_writereg}, {31'd0, e.wr});
            if (e.wr) check({tag, "_rd"}, {27'd0, bus.ex_mem_regdest}, {27'd0, e.rd});
        end
    endtask

    // single-cycle op: drive, push expectation, check after the edge
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic sel,
                         input logic [4:0] shamt, input logic [4:0] rd, input logic wr,
                         input logic mr, input logic mw, input logic [31:0] exp_wb);
        exp_t e;
        drive(op, a, b, imm, sel, shamt, rd, wr, mr, mw);
        e.wb = exp_wb; e.addr = exp_wb[8:2]; e.data = b;
        e.wre = mw; e.sel = mr; e.wr = wr; e.rd = rd;
        sb.push_back(e);
        @(negedge clock);
        check({tag, "_nostall"}, {31'd0, bus.ex_stall}, 32'd0);
        @(posedge clock); #1;
        compare_out(tag);
    endtask

    // hold a multiply until the stage releases it, counting stalled cycles
    task automatic do_mult(input string tag, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        drive(op, a, b, 32'd0, 1'b0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (n < 100) begin
            @(negedge clock);
            if (!bus.ex_stall) break;
            n++;
            @(posedge clock); #1;
            check({tag, "_bub_wr"},  {31'd0, bus.ex_mem_writereg}, 32'd0);
            check({tag, "_bub_wre"}, {31'd0, bus.ex_mem_wre}, 32'd0);
            check({tag, "_bub_wb"},  bus.ex_mem_wbvalue, 32'd0);
        end
        check({tag, "_stall_cycles"}, n, 33);
        e.wb = 32'd0; e.addr = 7'd0; e.data = 32'd0;
        e.wre = 1'b0; e.sel = 1'b0; e.wr = 1'b0; e.rd = 5'd3;
        sb.push_back(e);
        @(posedge clock); #1;
        compare_out({tag, "_retire"});
    endtask

    function automatic logic [63:0] prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv;
        if (sgn) begin
            sa  = {{32{a[31]}}, a};
            sbv = {{32{b[31]}}, b};
            return sa * sbv;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    initial begin
        logic [63:0] p;
        int n;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_wb",    bus.ex_mem_wbvalue, 32'd0);
        check("rst_wr",    {31'd0, bus.ex_mem_writereg}, 32'd0);
        check("rst_wre",   {31'd0, bus.ex_mem_wre}, 32'd0);
        check("rst_stall", {31'd0, bus.ex_stall}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        issue("add",  ALU_ADD,  32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 32'd12);
        issue("sw",   ALU_ADD,  32'h10, 32'h1414, 32'hC, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h1C);
        issue("lw",   ALU_ADD,  32'h10, 32'h1414, 32'hC, 1'b1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h1C);
        issue("slt",  ALU_SLT,  32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 32'd1);
        issue("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 32'd0);
        issue("sra",  ALU_SRA,  32'd0, 32'h80000000, 32'd0, 1'b0, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 32'hF8000000);
        issue("srl",  ALU_SRL,  32'd0, 32'h80000000, 32'd0, 1'b0, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 32'h08000000);
        issue("sll",  ALU_SLL,  32'd0, 32'h00000003, 32'd0, 1'b0, 5'd31, 5'd5, 1'b1, 1'b0, 1'b0, 32'h80000000);
        issue("sub",  ALU_SUB,  32'd3, 32'd5, 32'd0, 1'b0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE);
        issue("nor",  ALU_NOR,  32'hF0F0F0F0, 32'h0000FFFF, 32'd0, 1'b0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0F0F0000);
        issue("lui",  ALU_LUI,  32'd0, 32'd0, 32'hFFFF1234, 1'b1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h12340000);

        do_mult("mult", ALU_MULT, 32'd6, 32'hFFFFFFF9);
        p = prod(1'b1, 32'd6, 32'hFFFFFFF9);
        issue("mfhi1", ALU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, p[63:32]);
        issue("mflo1", ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, p[31:0]);
        check("mult_hi_const", p[63:32], 32'hFFFFFFFF);

        do_mult("multu", ALU_MULTU, 32'hFFFFFFFF, 32'd2);
        p = prod(1'b0, 32'hFFFFFFFF, 32'd2);
        issue("mfhi2", ALU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, p[63:32]);
        issue("mflo2", ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, p[31:0]);

        do_mult("mneg", ALU_MULT, 32'h80000000, 32'h80000000);
        p = prod(1'b1, 32'h80000000, 32'h80000000);
        issue("mfhi3", ALU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, p[63:32]);

        do_mult("mzero", ALU_MULT, 32'd0, 32'h12345678);
        issue("mflo4", ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0);

        // reset while the multiplier is ten steps into BUSY
        do_mult("mpre", ALU_MULTU, 32'd9, 32'd9);
        drive(ALU_MULT, 32'd7, 32'd7, 32'd0, 1'b0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (n < 11) begin
            @(negedge clock);
            if (!bus.ex_stall) break;
            n++;
            @(posedge clock); #1;
        end
        check("rmid_stalled", n, 11);
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("rmid_stall", {31'd0, bus.ex_stall}, 32'd0);
        check("rmid_wb",    bus.ex_mem_wbvalue, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        issue("rmid_mflo", ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0);
        issue("rmid_mfhi", ALU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0);

        do_mult("b2b_a", ALU_MULT, 32'd3, 32'd4);
        do_mult("b2b_b", ALU_MULT, 32'd5, 32'd5);
        issue("b2b_mflo", ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'd25);
        issue("b2b_mfhi", ALU_MFHI, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
